// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for the shared memory/I-O bus.
// Decodes the granted address to RAM, switch port or LED register; reads return one cycle later.
module mem_bus_arbiter #(
   parameter int                    data_width = 16,
   parameter int                    addr_width = 9,
   parameter logic [addr_width-1:0] SW_ADDR    = 9'h140,
   parameter logic [addr_width-1:0] LED_ADDR   = 9'h100
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  req1,
   input  logic [1:0]            cmd0,
   input  logic [1:0]            cmd1,
   input  logic [addr_width-1:0] addr0,
   input  logic [addr_width-1:0] addr1,
   input  logic [data_width-1:0] wdata0,
   input  logic [data_width-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [data_width-1:0] rdata,
   output logic [addr_width-1:0] ram_addr,
   output logic                  ram_we,
   output logic [data_width-1:0] ram_din,
   input  logic [data_width-1:0] ram_dout,
   input  logic [7:0]            sw,
   output logic [7:0]            led,
   output logic                  err
);

   localparam logic [1:0] MWRITE  = 2'b01;
   localparam logic [1:0] MREAD   = 2'b11;
   localparam logic [1:0] MILL    = 2'b10;
   localparam logic [1:0] SRC_RAM = 2'd0;
   localparam logic [1:0] SRC_SW  = 2'd1;
   localparam logic [1:0] SRC_LED = 2'd2;

   logic                  ptr_q, ptr_d;
   logic [7:0]            led_q, led_d;
   logic                  err_q, err_d;
   logic                  rd_vld_q;
   logic                  rd_id_q;
   logic [1:0]            rd_src_q, rd_src_d;
   logic [7:0]            sw_q;
   logic [data_width-1:0] rdata_q;
   logic [addr_width-1:0] ram_addr_q;
   logic [data_width-1:0] ram_din_q;

   logic                  vld0, vld1, any_gnt;
   logic [1:0]            g_cmd;
   logic [addr_width-1:0] g_addr;
   logic [data_width-1:0] g_wdata;
   logic                  g_led, g_sw, g_wr, g_rd, illegal;

   // Nothing is accepted while reset is held, so no RAM write can slip through.
   assign vld0 = reset & req0 & (cmd0 == MWRITE || cmd0 == MREAD);
   assign vld1 = reset & req1 & (cmd1 == MWRITE || cmd1 == MREAD);
   assign gnt0 = vld0 & (~vld1 | ~ptr_q);
   assign gnt1 = vld1 & (~vld0 | ptr_q);
   assign any_gnt = gnt0 | gnt1;

   assign g_cmd   = gnt1 ? cmd1   : cmd0;
   assign g_addr  = gnt1 ? addr1  : addr0;
   assign g_wdata = gnt1 ? wdata1 : wdata0;
   assign g_led   = (g_addr == LED_ADDR);
   assign g_sw    = (g_addr == SW_ADDR);
   assign g_wr    = any_gnt & (g_cmd == MWRITE);
   assign g_rd    = any_gnt & (g_cmd == MREAD);
   assign illegal = (req0 & (cmd0 == MILL)) | (req1 & (cmd1 == MILL));

   assign ram_we   = g_wr & ~g_led & ~g_sw;
   assign ram_addr = any_gnt ? g_addr  : ram_addr_q;
   assign ram_din  = any_gnt ? g_wdata : ram_din_q;

   assign ptr_d    = any_gnt ? gnt0 : ptr_q;
   assign led_d    = (g_wr & g_led) ? g_wdata[7:0] : led_q;
   assign err_d    = err_q | illegal | (g_wr & g_sw);
   assign rd_src_d = g_sw ? SRC_SW : (g_led ? SRC_LED : SRC_RAM);

   always_comb begin
      rdata = rdata_q;
      if (rd_vld_q) begin
         case (rd_src_q)
            SRC_SW:  rdata = {{(data_width-8){1'b0}}, sw_q};
            SRC_LED: rdata = {{(data_width-8){1'b0}}, led_q};
            default: rdata = ram_dout;
         endcase
      end
   end

   assign rvalid0 = rd_vld_q & ~rd_id_q;
   assign rvalid1 = rd_vld_q & rd_id_q;
   assign led     = led_q;
   assign err     = err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q      <= 1'b0;
         led_q      <= 8'h00;
         err_q      <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_id_q    <= 1'b0;
         rd_src_q   <= SRC_RAM;
         sw_q       <= 8'h00;
         rdata_q    <= '0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
      end else begin
         ptr_q      <= ptr_d;
         led_q      <= led_d;
         err_q      <= err_d;
         rd_vld_q   <= g_rd;
         rd_id_q    <= gnt1;
         rd_src_q   <= rd_src_d;
         sw_q       <= sw;
         rdata_q    <= rdata;
         ram_addr_q <= ram_addr;
         ram_din_q  <= ram_din;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a synchronous RAM model behind the bus.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [1:0]  cmd0 = 2'b00, cmd1 = 2'b00;
   logic [8:0]  addr0 = '0, addr1 = '0;
   logic [15:0] wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, ram_we, err;
   logic [15:0] rdata, ram_din, ram_dout;
   logic [8:0]  ram_addr;
   logic [7:0]  sw = 8'h00;
   logic [7:0]  led;

   logic [15:0] mem [0:511];
   int tests = 0;
   int fails = 0;

   mem_bus_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
      .ram_dout(ram_dout), .sw(sw), .led(led), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
      mem[9'h020] = 16'h1111;
      mem[9'h030] = 16'h2222;
   end

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   task automatic idle_inputs();
      req0 = 1'b0; req1 = 1'b0; cmd0 = 2'b00; cmd1 = 2'b00;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      tests++; if (led !== 8'h00) begin fails++; $display("FAIL reset_led got %h exp 00", led); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
      tests++; if ({gnt0, gnt1} !== 2'b00) begin fails++; $display("FAIL reset_gnt got %b exp 00", {gnt0, gnt1}); end
      tests++; if ({rvalid0, rvalid1} !== 2'b00) begin fails++; $display("FAIL reset_rvalid got %b exp 00", {rvalid0, rvalid1}); end
      tests++; if (rdata !== 16'h0000) begin fails++; $display("FAIL reset_rdata got %h exp 0000", rdata); end
      @(negedge clk); reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL idle_ram_we cycle %0d got %b exp 0", i, ram_we); end
      end
   endtask

   task automatic test_contention();
      @(negedge clk);
      req0 = 1'b1; cmd0 = 2'b11; addr0 = 9'h020;
      req1 = 1'b1; cmd1 = 2'b11; addr1 = 9'h030;
      for (int i = 0; i < 6; i++) begin
         #1;
         tests++;
         if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            fails++; $display("FAIL contend_gnt cycle %0d got %b exp %b", i, {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
         end
         if (i > 0) begin
            tests++;
            if ({rvalid0, rvalid1} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
               fails++; $display("FAIL contend_rvalid cycle %0d got %b", i, {rvalid0, rvalid1});
            end
            tests++;
            if (rdata !== ((i % 2 == 1) ? 16'h1111 : 16'h2222)) begin
               fails++; $display("FAIL contend_rdata cycle %0d got %h", i, rdata);
            end
         end
         @(negedge clk);
      end
      idle_inputs();
      #1;
      tests++; if ({rvalid0, rvalid1} !== 2'b01) begin fails++; $display("FAIL contend_last_rvalid got %b exp 01", {rvalid0, rvalid1}); end
      tests++; if (rdata !== 16'h2222) begin fails++; $display("FAIL contend_last_rdata got %h exp 2222", rdata); end
      @(negedge clk);
      tests++; if ({rvalid0, rvalid1} !== 2'b00) begin fails++; $display("FAIL contend_rvalid_pulse got %b exp 00", {rvalid0, rvalid1}); end
      tests++; if (rdata !== 16'h2222) begin fails++; $display("FAIL rdata_hold got %h exp 2222", rdata); end
   endtask

   task automatic test_led();
      req0 = 1'b1; cmd0 = 2'b01; addr0 = 9'h100; wdata0 = 16'h00A5;
      #1;
      tests++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL led_wr_gnt got %b exp 1", gnt0); end
      tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL led_wr_ram_we got %b exp 0", ram_we); end
      @(negedge clk);
      tests++; if (led !== 8'hA5) begin fails++; $display("FAIL led_value got %h exp a5", led); end
      cmd0 = 2'b11;
      @(negedge clk);
      idle_inputs();
      #1;
      tests++; if (rvalid0 !== 1'b1) begin fails++; $display("FAIL led_rd_rvalid0 got %b exp 1", rvalid0); end
      tests++; if (rdata !== 16'h00A5) begin fails++; $display("FAIL led_rd_rdata got %h exp 00a5", rdata); end
      @(negedge clk);
   endtask

   task automatic test_sw();
      sw = 8'h3C;
      req1 = 1'b1; cmd1 = 2'b11; addr1 = 9'h140;
      @(negedge clk);
      idle_inputs();
      sw = 8'hC3;
      #1;
      tests++; if (rvalid1 !== 1'b1) begin fails++; $display("FAIL sw_rd_rvalid1 got %b exp 1", rvalid1); end
      tests++; if (rdata !== 16'h003C) begin fails++; $display("FAIL sw_rd_rdata got %h exp 003c", rdata); end
      @(negedge clk);
      req1 = 1'b1; cmd1 = 2'b01; addr1 = 9'h140; wdata1 = 16'h00FF;
      #1;
      tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL sw_wr_ram_we got %b exp 0", ram_we); end
      @(negedge clk);
      idle_inputs();
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL sw_wr_err got %b exp 1", err); end
      tests++; if (led !== 8'hA5) begin fails++; $display("FAIL sw_wr_led got %h exp a5", led); end
   endtask

   task automatic test_ram();
      req1 = 1'b1; cmd1 = 2'b01; addr1 = 9'h010; wdata1 = 16'hBEEF;
      #1;
      tests++; if (gnt1 !== 1'b1) begin fails++; $display("FAIL ram_wr_gnt got %b exp 1", gnt1); end
      tests++; if (ram_we !== 1'b1) begin fails++; $display("FAIL ram_wr_we got %b exp 1", ram_we); end
      tests++; if (ram_addr !== 9'h010) begin fails++; $display("FAIL ram_wr_addr got %h exp 010", ram_addr); end
      tests++; if (ram_din !== 16'hBEEF) begin fails++; $display("FAIL ram_wr_din got %h exp beef", ram_din); end
      @(negedge clk);
      cmd1 = 2'b11; wdata1 = 16'h0000;
      @(negedge clk);
      idle_inputs();
      addr1 = 9'h1FF;
      #1;
      tests++; if (rvalid1 !== 1'b1) begin fails++; $display("FAIL ram_rd_rvalid1 got %b exp 1", rvalid1); end
      tests++; if (rdata !== 16'hBEEF) begin fails++; $display("FAIL ram_rd_rdata got %h exp beef", rdata); end
      tests++; if (ram_addr !== 9'h010) begin fails++; $display("FAIL ram_addr_hold got %h exp 010", ram_addr); end
      tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL ram_idle_we got %b exp 0", ram_we); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      // One port-0 grant leaves the pointer at port 1 unless reset restores it.
      req0 = 1'b1; cmd0 = 2'b11; addr0 = 9'h020;
      @(posedge clk);
      #1;
      idle_inputs();
      reset = 1'b0;
      #1;
      tests++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL midrst_rvalid0 got %b exp 0", rvalid0); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL midrst_err got %b exp 0", err); end
      tests++; if (led !== 8'h00) begin fails++; $display("FAIL midrst_led got %h exp 00", led); end
      @(negedge clk);
      tests++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL midrst_rvalid_held got %b exp 0", rvalid0); end
      reset = 1'b1;
      @(negedge clk);
      req0 = 1'b1; cmd0 = 2'b11; addr0 = 9'h020;
      req1 = 1'b1; cmd1 = 2'b11; addr1 = 9'h030;
      #1;
      tests++; if ({gnt0, gnt1} !== 2'b10) begin fails++; $display("FAIL midrst_first_gnt got %b exp 10", {gnt0, gnt1}); end
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_illegal();
      req0 = 1'b1; cmd0 = 2'b10; addr0 = 9'h010;
      req1 = 1'b1; cmd1 = 2'b00; addr1 = 9'h010;
      #1;
      tests++; if ({gnt0, gnt1} !== 2'b00) begin fails++; $display("FAIL illegal_gnt got %b exp 00", {gnt0, gnt1}); end
      tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL illegal_ram_we got %b exp 0", ram_we); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL illegal_err_pre got %b exp 0", err); end
      @(negedge clk);
      idle_inputs();
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL illegal_err got %b exp 1", err); end
      @(negedge clk);
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b exp 1", err); end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_led();
      test_sw();
      test_ram();
      test_reset_mid();
      test_illegal();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
